// File: rtl/uart_tx_drain_if.sv
// FIFO read-port bundle between the 8-bit FIFO and the UART transmit drain.
// master: the drain (issues fifo_rd_en); slave: the FIFO (drives empty/data).
interface uart_tx_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops one byte at a time from the FIFO and shifts it out as a
// UART frame on tx, LSB first (start, 8 data, [parity], stop).
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit after
// data bit 7 (11-bit frame). Default build is plain 8N1.
// All outputs are registered: the next-state logic computes the value each
// output must have in the state being entered, and the flops hold it.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_drain_if.master   fifo,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       idx_r, idx_s;
  logic [7:0]       shift_r, shift_s;
  logic             tx_r, tx_s;
  logic             busy_r, busy_s;
  logic             rd_en_r, rd_en_s;
  logic             done_r, done_s;
  logic             bit_end_s;

`ifdef UART_TX_PARITY_EN
  logic             par_r, par_s;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  assign bit_end_s = (cnt_r == CNT_LAST);

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
`ifdef UART_TX_PARITY_EN
    par_s   = par_r;
`endif
    case (state_r)
      IDLE: begin
        if (!fifo.fifo_empty) begin
          state_s = POP;
        end else begin
          state_s = IDLE;
        end
      end
      POP: begin
        state_s = LOAD;
      end
      LOAD: begin
        shift_s = fifo.fifo_data;
        cnt_s   = {CNT_W{1'b0}};
        idx_s   = 3'd0;
`ifdef UART_TX_PARITY_EN
        par_s   = even_parity(fifo.fifo_data);
`endif
        state_s = START;
      end
      START: begin
        if (bit_end_s) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = DATA;
        end else begin
          cnt_s   = cnt_r + 1'b1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_s   = {CNT_W{1'b0}};
          shift_s = {1'b0, shift_r[7:1]};
          idx_s   = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            state_s = DATA;
          end
        end else begin
          cnt_s   = cnt_r + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = STOP;
        end else begin
          cnt_s   = cnt_r + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
        idx_s   = 3'd0;
        shift_s = 8'd0;
      end
    endcase

    // Outputs for the state being entered, so the flops present them in step.
    tx_s    = 1'b1;
    busy_s  = 1'b0;
    rd_en_s = 1'b0;
    done_s  = 1'b0;
    case (state_s)
      IDLE: begin
        tx_s = 1'b1;
      end
      POP: begin
        busy_s  = 1'b1;
        rd_en_s = 1'b1;
      end
      LOAD: begin
        busy_s = 1'b1;
      end
      START: begin
        busy_s = 1'b1;
        tx_s   = 1'b0;
      end
      DATA: begin
        busy_s = 1'b1;
        tx_s   = shift_s[0];
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        busy_s = 1'b1;
        tx_s   = par_s;
      end
`endif
      STOP: begin
        busy_s = 1'b1;
        done_s = (cnt_s == CNT_LAST);
      end
      default: begin
        tx_s = 1'b1;
      end
    endcase
  end

  // State, datapath and registered-output flops; reset parks the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      rd_en_r <= 1'b0;
      done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      rd_en_r <= rd_en_s;
      done_r  <= done_s;
`ifdef UART_TX_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

  assign tx              = tx_r;
  assign busy            = busy_r;
  assign frame_done      = done_r;
  assign fifo.fifo_rd_en = rd_en_r;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain at CLKS_PER_BIT=4 with a queue-style
// FIFO model. Honours UART_TX_PARITY_EN for the expected frame length/bits.
module tb_uart_tx_drain;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB     = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NB     = 10;
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic tx, busy, frame_done;

  uart_tx_drain_if bus ();

  uart_tx_drain #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo       (bus),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: storage written by the stimulus, read pointer advanced on pops.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int underflows = 0;
  int overlaps = 0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  // Serve pops one cycle late and track pop-related protocol events.
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      if (wr_ptr == rd_ptr) begin
        underflows <= underflows + 1;
      end else begin
        bus.fifo_data <= mem[rd_ptr[7:0]];
        rd_ptr <= rd_ptr + 1;
      end
      pops <= pops + 1;
    end
    if (bus.fifo_rd_en && frame_done) overlaps <= overlaps + 1;
  end

  int vec = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Reference frame: bit i is the i-th bit put on the line.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    if (PAR_EN) begin
      f[9]  = ^d;
      f[10] = 1'b1;
    end else begin
      f[9]  = 1'b1;
      f[10] = 1'b1;
    end
    return f;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;   // 8N1 line sequence, leftmost bit sent first
    logic       par;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [10:0] table_frame(input vec_t v);
    logic [10:0] f;
    for (int i = 0; i < 9; i++) f[i] = v.seq[9-i];
    if (PAR_EN) begin
      f[9]  = v.par;
      f[10] = v.seq[0];
    end else begin
      f[9]  = v.seq[0];
      f[10] = 1'b1;
    end
    return f;
  endfunction

  // Wait (bounded) for a start bit, then check every cycle of the frame.
  task automatic run_frame(input logic [10:0] exp, input int exp_wait, input string tag);
    int waited = 0;
    bit got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        got = 1'b1;
        break;
      end
      waited++;
    end
    chk({tag, " start_seen"}, 32'(got), 32'd1);
    if (got) begin
      if (exp_wait >= 0) chk({tag, " idle_gap"}, waited, exp_wait);
      for (int c = 0; c < NB*CPB; c++) begin
        if (c > 0) @(negedge clk);
        chk({tag, " tx"}, 32'(tx), 32'(exp[c/CPB]));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " frame_done"}, 32'(frame_done), 32'(c == NB*CPB-1));
        chk({tag, " rd_en_in_frame"}, 32'(bus.fifo_rd_en), 32'd0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [7:0] burst [4];
    int n;

    tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
    tbl[1] = '{8'h00, 10'b0000000001, 1'b0};
    tbl[2] = '{8'hFF, 10'b0111111111, 1'b0};
    tbl[3] = '{8'h07, 10'b0111000001, 1'b1};
    tbl[4] = '{8'h03, 10'b0110000001, 1'b0};
    tbl[5] = '{8'h80, 10'b0000000011, 1'b1};
    tbl[6] = '{8'h3C, 10'b0001111001, 1'b0};

    // Reset held with a non-empty FIFO: line idle, no pop.
    rst_n = 1'b0;
    push(tbl[0].data);
    repeat (10) begin
      @(negedge clk);
      chk("reset tx", 32'(tx), 32'd1);
      chk("reset rd_en", 32'(bus.fifo_rd_en), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset frame_done", 32'(frame_done), 32'd0);
    end
    rst_n = 1'b1;
    p0 = pops;
    run_frame(table_frame(tbl[0]), 2, "post_reset");
    chk("post_reset pops", pops - p0, 32'd1);

    // Table: single byte each, FIFO runs empty after every frame.
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      chk("tbl idle busy", 32'(busy), 32'd0);
      chk("tbl idle tx", 32'(tx), 32'd1);
      p0 = pops;
      push(tbl[i].data);
      run_frame(table_frame(tbl[i]), 2, "tbl");
      chk("tbl pops", pops - p0, 32'd1);
    end

    // Back-to-back: 00 then FF queued together.
    @(negedge clk);
    p0 = pops;
    push(8'h00);
    push(8'hFF);
    run_frame(table_frame(tbl[1]), 2, "b2b_first");
    run_frame(table_frame(tbl[2]), 3, "b2b_second");
    chk("b2b pops", pops - p0, 32'd2);

    // Empty FIFO for 100 cycles.
    repeat (100) begin
      @(negedge clk);
      chk("empty rd_en", 32'(bus.fifo_rd_en), 32'd0);
      chk("empty tx", 32'(tx), 32'd1);
      chk("empty busy", 32'(busy), 32'd0);
    end

    // Reset during data bit 3 of an all-zero byte.
    push(8'h00);
    begin
      bit got = 1'b0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (tx === 1'b0) begin
          got = 1'b1;
          break;
        end
      end
      chk("midrst start_seen", 32'(got), 32'd1);
    end
    repeat (CPB*4 + 1) @(negedge clk);
    chk("midrst tx before reset", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst tx", 32'(tx), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = pops;
    repeat (20) begin
      @(negedge clk);
      chk("midrst idle tx", 32'(tx), 32'd1);
      chk("midrst idle busy", 32'(busy), 32'd0);
    end
    chk("midrst no pop", pops - p0, 32'd0);
    push(tbl[6].data);
    run_frame(table_frame(tbl[6]), 2, "midrst_fresh");
    chk("midrst fresh pops", pops - p0, 32'd1);

    // Random bursts against the reference model.
    for (int b = 0; b < 6; b++) begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      n = $urandom_range(1, 4);
      p0 = pops;
      for (int j = 0; j < n; j++) begin
        burst[j] = 8'($urandom);
        push(burst[j]);
      end
      for (int j = 0; j < n; j++) begin
        run_frame(ref_frame(burst[j]), (j == 0) ? 2 : 3, "rand");
      end
      chk("rand pops", pops - p0, n);
    end

    repeat (3) @(negedge clk);
    chk("no underflow pops", underflows, 32'd0);
    chk("done/rd_en overlap", overlaps, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule
